// File: rtl/vxe_biu_pkg.sv
// ---------------------------------------------------------------------------
// vxe_biu_pkg
// Shared definitions for the BIU read-side blocks:
//   - AXI4 response codes
//   - clog2 helper usable in parameter expressions
//   - width of a client index for a given client count
//   - width of the per-client outstanding-read counters
// ---------------------------------------------------------------------------
package vxe_biu_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam int CNT_WIDTH = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // A client index is never narrower than one bit, even for two clients
  function automatic int cidxWidth(input int nClients);
    return (nClients <= 2) ? 1 : clog2(nClients);
  endfunction

endpackage

// File: rtl/vxe_rr_arb.sv
// ---------------------------------------------------------------------------
// vxe_rr_arb
// Purely combinational round-robin priority selector. Starting at i_ptr and
// wrapping modulo NCLIENTS, the first set bit of i_req wins.
// Ports:
//   i_req  - request vector, one bit per client
//   i_ptr  - index of the highest-priority client this cycle
//   o_gnt  - one-hot grant (zero when nothing is requested)
//   o_idx  - index of the granted client (zero when nothing is requested)
//   o_any  - at least one request present
// ---------------------------------------------------------------------------
module vxe_rr_arb
  import vxe_biu_pkg::*;
#(
  parameter int NCLIENTS = 4,
  parameter int IDX_W    = cidxWidth(NCLIENTS)
) (
  input  logic [NCLIENTS-1:0] i_req,
  input  logic [IDX_W-1:0]    i_ptr,
  output logic [NCLIENTS-1:0] o_gnt,
  output logic [IDX_W-1:0]    o_idx,
  output logic                o_any
);

  logic [IDX_W-1:0] w_cand;

  // Walk the offsets from farthest to nearest so the nearest requester
  // (lowest offset from the pointer) is the one left standing.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int off = NCLIENTS - 1; off >= 0; off--) begin
      w_cand = IDX_W'((int'(i_ptr) + off) % NCLIENTS);
      if (i_req[w_cand]) begin
        o_any = 1'b1;
        o_idx = w_cand;
      end
    end
    if (o_any) begin
      o_gnt[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/vxe_biu_rd_arb.sv
// ---------------------------------------------------------------------------
// vxe_biu_rd_arb
// Merges NCLIENTS read clients onto the single BIU read interface and steers
// each BIU response back to its client by CID. Each client may have at most
// MAX_OUTST reads in flight.
// Ports:
//   M_AXI4_ACLK / M_AXI4_ARESETn  - clock, async active-low reset
//   cl_arvalid / cl_araddr        - per-client read requests
//   cl_arpop                      - per-client request accepted (one-hot/zero)
//   cl_rvalid / cl_rready         - per-client response handshake
//   cl_rdata / cl_rresp           - response payload shared by all clients
//   biu_ar*                       - request slot towards the BIU
//   biu_r*                        - response path from the BIU
//   arb_idle                      - nothing held, nothing outstanding
//   err_badcid                    - sticky: response with out-of-range CID
// ---------------------------------------------------------------------------
module vxe_biu_rd_arb
  import vxe_biu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CID_WIDTH  = 8,
  parameter int NCLIENTS   = 4,
  parameter int MAX_OUTST  = 4
) (
  input  logic                         M_AXI4_ACLK,
  input  logic                         M_AXI4_ARESETn,
  input  logic [NCLIENTS-1:0]          cl_arvalid,
  input  logic [NCLIENTS*ADDR_WIDTH-1:0] cl_araddr,
  output logic [NCLIENTS-1:0]          cl_arpop,
  output logic [NCLIENTS-1:0]          cl_rvalid,
  output logic [DATA_WIDTH-1:0]        cl_rdata,
  output logic [1:0]                   cl_rresp,
  input  logic [NCLIENTS-1:0]          cl_rready,
  output logic [CID_WIDTH-1:0]         biu_arcid,
  output logic [ADDR_WIDTH-1:0]        biu_araddr,
  output logic                         biu_arvalid,
  input  logic                         biu_arpop,
  input  logic [CID_WIDTH-1:0]         biu_rcid,
  input  logic [DATA_WIDTH-1:0]        biu_rdata,
  input  logic [1:0]                   biu_rresp,
  input  logic                         biu_rpush,
  output logic                         biu_rready,
  output logic                         arb_idle,
  output logic                         err_badcid
);

  localparam int IDX_W = cidxWidth(NCLIENTS);

  logic                  r_arvalid;
  logic [IDX_W-1:0]      r_arcid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [IDX_W-1:0]      r_rrPtr;
  logic [CNT_WIDTH-1:0]  r_cnt [NCLIENTS];
  logic                  r_rv;
  logic [IDX_W-1:0]      r_rcid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;
  logic                  r_badcid;

  logic                  w_slotFree;
  logic [NCLIENTS-1:0]   w_elig;
  logic [NCLIENTS-1:0]   w_req;
  logic [NCLIENTS-1:0]   w_gnt;
  logic [IDX_W-1:0]      w_gntIdx;
  logic                  w_gntAny;
  logic [ADDR_WIDTH-1:0] w_gntAddr;
  logic [IDX_W-1:0]      w_ptrNext;
  logic [NCLIENTS-1:0]   w_dec;
  logic                  w_deliver;
  logic                  w_badcid;
  logic                  w_rspAccept;
  logic                  w_capture;
  logic                  w_cntZero;

  assign w_slotFree = ~r_arvalid | biu_arpop;

  genvar gi;
  generate
    for (gi = 0; gi < NCLIENTS; gi++) begin : g_client
      assign w_elig[gi]    = cl_arvalid[gi] && (r_cnt[gi] != CNT_WIDTH'(MAX_OUTST));
      assign cl_rvalid[gi] = r_rv && (r_rcid == IDX_W'(gi));
    end
  endgenerate

  // Gating the request vector with slot_free keeps cl_arpop low whenever
  // the slot cannot be reloaded.
  assign w_req = w_elig & {NCLIENTS{w_slotFree}};

  vxe_rr_arb #(
    .NCLIENTS (NCLIENTS),
    .IDX_W    (IDX_W)
  ) u_rrArb (
    .i_req (w_req),
    .i_ptr (r_rrPtr),
    .o_gnt (w_gnt),
    .o_idx (w_gntIdx),
    .o_any (w_gntAny)
  );

  assign cl_arpop  = w_gnt;
  assign w_ptrNext = (w_gntIdx == IDX_W'(NCLIENTS - 1)) ? '0 : w_gntIdx + IDX_W'(1);

  always_comb begin
    w_gntAddr = '0;
    for (int i = 0; i < NCLIENTS; i++) begin
      if (w_gnt[i]) begin
        w_gntAddr = cl_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  // Response side: a held response only blocks the BIU while its own client
  // is stalling; out-of-range CIDs are swallowed without loading.
  assign w_dec       = cl_rvalid & cl_rready;
  assign w_deliver   = |w_dec;
  assign biu_rready  = ~r_rv | cl_rready[r_rcid];
  assign w_badcid    = ({1'b0, biu_rcid} >= (CID_WIDTH+1)'(NCLIENTS));
  assign w_rspAccept = biu_rpush & biu_rready;
  assign w_capture   = w_rspAccept & ~w_badcid;

  always_comb begin
    w_cntZero = 1'b1;
    for (int i = 0; i < NCLIENTS; i++) begin
      if (r_cnt[i] != '0) begin
        w_cntZero = 1'b0;
      end
    end
  end

  assign arb_idle    = ~r_arvalid & ~r_rv & w_cntZero;
  assign biu_arvalid = r_arvalid;
  assign biu_arcid   = CID_WIDTH'(r_arcid);
  assign biu_araddr  = r_araddr;
  assign cl_rdata    = r_rdata;
  assign cl_rresp    = r_rresp;
  assign err_badcid  = r_badcid;

  // Request slot and round-robin pointer. The slot keeps its last cid/addr
  // when it drains; only the valid flag drops.
  always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
    if (!M_AXI4_ARESETn) begin
      r_arvalid <= 1'b0;
      r_arcid   <= '0;
      r_araddr  <= '0;
      r_rrPtr   <= '0;
    end else if (w_gntAny) begin
      r_arvalid <= 1'b1;
      r_arcid   <= w_gntIdx;
      r_araddr  <= w_gntAddr;
      r_rrPtr   <= w_ptrNext;
    end else if (w_slotFree) begin
      r_arvalid <= 1'b0;
    end
  end

  // Outstanding counters: grant increments, delivery decrements, both at
  // once cancel out.
  always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
    if (!M_AXI4_ARESETn) begin
      for (int i = 0; i < NCLIENTS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCLIENTS; i++) begin
        if (w_gnt[i] && !w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
        end else if (!w_gnt[i] && w_dec[i]) begin
          r_cnt[i] <= r_cnt[i] - CNT_WIDTH'(1);
        end
      end
    end
  end

  // Single-entry response register; a capture in the delivery cycle reloads
  // it so the valid flag stays up.
  always_ff @(posedge M_AXI4_ACLK or negedge M_AXI4_ARESETn) begin
    if (!M_AXI4_ARESETn) begin
      r_rv     <= 1'b0;
      r_rcid   <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
      r_badcid <= 1'b0;
    end else begin
      if (w_capture) begin
        r_rv    <= 1'b1;
        r_rcid  <= biu_rcid[IDX_W-1:0];
        r_rdata <= biu_rdata;
        r_rresp <= biu_rresp;
      end else if (w_deliver) begin
        r_rv <= 1'b0;
      end
      if (w_rspAccept && w_badcid) begin
        r_badcid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vxe_biu_rd_arb.sv
// ---------------------------------------------------------------------------
// tb_vxe_biu_rd_arb
// Self-checking bench for vxe_biu_rd_arb (4 clients, 4 outstanding each).
// A reference model follows the arbitration and response rules every cycle;
// a queue stands in for the BIU, returning responses in request order.
// ---------------------------------------------------------------------------
module tb_vxe_biu_rd_arb;
  import vxe_biu_pkg::*;

  localparam int NCL  = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = 8;
  localparam int MAXO = 4;

  logic              clock = 1'b0;
  logic              resetN = 1'b0;
  logic [NCL-1:0]    clArvalid, clArpop, clRvalid, clRready;
  logic [NCL*AW-1:0] clAraddr;
  logic [DW-1:0]     clRdata;
  logic [1:0]        clRresp;
  logic [CW-1:0]     biuArcid;
  logic [AW-1:0]     biuAraddr;
  logic              biuArvalid, biuArpop;
  logic [CW-1:0]     biuRcid;
  logic [DW-1:0]     biuRdata;
  logic [1:0]        biuRresp;
  logic              biuRpush, biuRready;
  logic              arbIdle, errBadcid;

  int testCount = 0;
  int failCount = 0;

  // Reference model state
  logic          mSlotV;
  int            mSlotCid;
  logic [AW-1:0] mSlotAddr;
  int            mPtr;
  int            mCnt [NCL];
  logic          mRv;
  int            mRcid;
  logic [DW-1:0] mRdata;
  logic [1:0]    mRresp;
  logic          mBad;
  int            mGrant;
  logic          mRready;
  logic          pushFromQ;
  int            biuQ [$];
  int            grantLog [$];
  int            grantCnt [NCL];
  int            expOrder [6] = '{0, 1, 2, 3, 0, 1};

  vxe_biu_rd_arb #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .CID_WIDTH  (CW),
    .NCLIENTS   (NCL),
    .MAX_OUTST  (MAXO)
  ) dut (
    .M_AXI4_ACLK    (clock),
    .M_AXI4_ARESETn (resetN),
    .cl_arvalid     (clArvalid),
    .cl_araddr      (clAraddr),
    .cl_arpop       (clArpop),
    .cl_rvalid      (clRvalid),
    .cl_rdata       (clRdata),
    .cl_rresp       (clRresp),
    .cl_rready      (clRready),
    .biu_arcid      (biuArcid),
    .biu_araddr     (biuAraddr),
    .biu_arvalid    (biuArvalid),
    .biu_arpop      (biuArpop),
    .biu_rcid       (biuRcid),
    .biu_rdata      (biuRdata),
    .biu_rresp      (biuRresp),
    .biu_rpush      (biuRpush),
    .biu_rready     (biuRready),
    .arb_idle       (arbIdle),
    .err_badcid     (errBadcid)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mSlotV = 1'b0; mSlotCid = 0; mSlotAddr = '0; mPtr = 0;
    mRv = 1'b0; mRcid = 0; mRdata = '0; mRresp = '0; mBad = 1'b0;
    for (int i = 0; i < NCL; i++) begin
      mCnt[i] = 0;
      grantCnt[i] = 0;
    end
    biuQ.delete();
    grantLog.delete();
  endtask

  // Expected values from the current model state and current inputs
  task automatic checkOutput();
    logic           slotFree;
    logic [NCL-1:0] expPop, expRvalid;
    int             busy;
    slotFree = !mSlotV || biuArpop;
    mGrant = -1;
    if (slotFree) begin
      for (int k = 0; k < NCL; k++) begin
        if (mGrant < 0 && clArvalid[(mPtr + k) % NCL] && mCnt[(mPtr + k) % NCL] < MAXO) begin
          mGrant = (mPtr + k) % NCL;
        end
      end
    end
    expPop = '0;
    if (mGrant >= 0) expPop[mGrant] = 1'b1;
    expRvalid = '0;
    if (mRv) expRvalid[mRcid] = 1'b1;
    mRready = !mRv || clRready[mRcid];
    busy = 0;
    for (int i = 0; i < NCL; i++) busy += mCnt[i];

    checkVal("arpop", clArpop, expPop);
    checkVal("arvalid", biuArvalid, mSlotV);
    if (mSlotV) begin
      checkVal("arcid", biuArcid, mSlotCid);
      checkVal("araddr", biuAraddr, mSlotAddr);
    end
    checkVal("rvalid", clRvalid, expRvalid);
    if (mRv) begin
      checkVal("rdata", clRdata, mRdata);
      checkVal("rresp", clRresp, mRresp);
    end
    checkVal("rready", biuRready, mRready);
    checkVal("idle", arbIdle, (!mSlotV && !mRv && busy == 0));
    checkVal("badcid", errBadcid, mBad);

    for (int i = 0; i < NCL; i++) begin
      if (clArpop[i]) begin
        grantCnt[i]++;
        grantLog.push_back(i);
      end
    end
  endtask

  // Advance the model across one rising edge
  task automatic stepModel();
    logic slotFree, deliver, accepted;
    slotFree = !mSlotV || biuArpop;
    deliver  = mRv && clRready[mRcid];
    accepted = biuRpush && mRready;
    if (accepted && pushFromQ) biuQ.delete(0);
    if (accepted && int'(biuRcid) >= NCL) mBad = 1'b1;
    if (mSlotV && biuArpop) biuQ.push_back(mSlotCid);
    if (deliver) mCnt[mRcid]--;
    if (mGrant >= 0) begin
      mSlotV    = 1'b1;
      mSlotCid  = mGrant;
      mSlotAddr = clAraddr[mGrant*AW +: AW];
      mPtr      = (mGrant + 1) % NCL;
      mCnt[mGrant]++;
    end else if (slotFree) begin
      mSlotV = 1'b0;
    end
    if (accepted && int'(biuRcid) < NCL) begin
      mRv    = 1'b1;
      mRcid  = int'(biuRcid);
      mRdata = biuRdata;
      mRresp = biuRresp;
    end else if (deliver) begin
      mRv = 1'b0;
    end
  endtask

  // One clock cycle: drive inputs, check, advance. pushMode 0 = no response,
  // 1 = BIU returns its oldest accepted request, 2 = response with cid 7.
  task automatic applyStimulus(input logic [NCL-1:0] arv, input logic [NCL-1:0] rdy,
                               input logic pop, input int pushMode,
                               input logic [DW-1:0] data, input logic [1:0] resp);
    clArvalid = arv;
    clRready  = rdy;
    biuArpop  = pop;
    biuRpush  = 1'b0;
    biuRcid   = '0;
    biuRdata  = data;
    biuRresp  = resp;
    pushFromQ = 1'b0;
    if (pushMode == 1 && biuQ.size() > 0) begin
      biuRpush  = 1'b1;
      biuRcid   = CW'(biuQ[0]);
      pushFromQ = 1'b1;
    end else if (pushMode == 2) begin
      biuRpush = 1'b1;
      biuRcid  = 8'd7;
    end
    #1;
    checkOutput();
    stepModel();
    @(posedge clock);
    #1;
  endtask

  // Assert reset (possibly mid-traffic), check outputs straight away, release
  task automatic doReset();
    resetN = 1'b0;
    #1;
    checkVal("rstArvalid", biuArvalid, 0);
    checkVal("rstArcid", biuArcid, 0);
    checkVal("rstAraddr", biuAraddr, 0);
    checkVal("rstRvalid", clRvalid, 0);
    checkVal("rstRdata", clRdata, 0);
    checkVal("rstRresp", clRresp, 0);
    checkVal("rstBadcid", errBadcid, 0);
    checkVal("rstIdle", arbIdle, 1);
    modelReset();
    clArvalid = '0;
    clRready  = '1;
    biuArpop  = 1'b0;
    biuRpush  = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    clArvalid = '0; clAraddr = '0; clRready = '1; biuArpop = 1'b0;
    biuRcid = '0; biuRdata = '0; biuRresp = '0; biuRpush = 1'b0;
    doReset();

    // Single client round trip
    clAraddr[31:0] = 32'h0000_1000;
    applyStimulus(4'b0001, 4'hF, 1'b1, 0, '0, RESP_OKAY);
    checkVal("singleArvalid", biuArvalid, 1);
    checkVal("singleArcid", biuArcid, 0);
    checkVal("singleAraddr", biuAraddr, 32'h0000_1000);
    applyStimulus(4'b0000, 4'hF, 1'b1, 0, '0, RESP_OKAY);
    applyStimulus(4'b0000, 4'hF, 1'b1, 1, 32'hDEAD_BEEF, RESP_OKAY);
    checkVal("singleRvalid", clRvalid, 4'b0001);
    checkVal("singleRdata", clRdata, 32'hDEAD_BEEF);
    checkVal("singleRresp", clRresp, 0);
    applyStimulus(4'b0000, 4'hF, 1'b1, 0, '0, RESP_OKAY);
    checkVal("singleIdle", arbIdle, 1);

    // Fairness: everybody requesting, BIU always accepting
    doReset();
    for (int c = 0; c < 40; c++) applyStimulus(4'hF, 4'hF, 1'b1, 1, $urandom, RESP_OKAY);
    checkVal("fairTotal", grantLog.size(), 40);
    for (int k = 0; k < 6; k++) begin
      checkVal("fairOrder", (k < grantLog.size()) ? grantLog[k] : -1, expOrder[k]);
    end
    for (int i = 0; i < NCL; i++) checkVal("fairShare", grantCnt[i], 10);

    // Backpressure: slot must hold while the BIU refuses
    doReset();
    clAraddr = {32'h0000_A300, 32'h0000_A200, 32'h0000_A100, 32'h0000_A000};
    applyStimulus(4'hF, 4'hF, 1'b0, 0, '0, RESP_OKAY);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'hF, 4'hF, 1'b0, 0, '0, RESP_OKAY);
      checkVal("bpArvalid", biuArvalid, 1);
      checkVal("bpArcid", biuArcid, 0);
      checkVal("bpAraddr", biuAraddr, 32'h0000_A000);
    end
    applyStimulus(4'hF, 4'hF, 1'b1, 0, '0, RESP_OKAY);
    checkVal("bpNextCid", biuArcid, 1);
    checkVal("bpNextAddr", biuAraddr, 32'h0000_A100);
    for (int c = 0; c < 10; c++) applyStimulus(4'h0, 4'hF, 1'b1, 1, $urandom, RESP_OKAY);
    checkVal("bpIdle", arbIdle, 1);

    // Outstanding limit on client 2
    doReset();
    for (int c = 0; c < 8; c++) applyStimulus(4'b0100, 4'hF, 1'b1, 0, '0, RESP_OKAY);
    checkVal("limitGrants", grantCnt[2], 4);
    applyStimulus(4'b0100, 4'hF, 1'b1, 1, 32'h2222_0001, RESP_OKAY);
    for (int c = 0; c < 6; c++) applyStimulus(4'b0100, 4'hF, 1'b1, 0, '0, RESP_OKAY);
    checkVal("limitRefill", grantCnt[2], 5);
    for (int c = 0; c < 14; c++) applyStimulus(4'h0, 4'hF, 1'b1, 1, $urandom, RESP_SLVERR);
    checkVal("limitIdle", arbIdle, 1);

    // Response steering with client 1 stalling
    doReset();
    applyStimulus(4'b1000, 4'hF, 1'b1, 0, '0, RESP_OKAY);
    applyStimulus(4'b0010, 4'hF, 1'b1, 0, '0, RESP_OKAY);
    applyStimulus(4'b1000, 4'hF, 1'b1, 0, '0, RESP_OKAY);
    for (int c = 0; c < 10; c++) applyStimulus(4'h0, 4'b1101, 1'b1, 1, 32'h5000_0000 + c, RESP_EXOKAY);
    checkVal("steerHold", biuRready, 0);
    checkVal("steerRvalid", clRvalid, 4'b0010);
    for (int c = 0; c < 6; c++) applyStimulus(4'h0, 4'hF, 1'b1, 1, 32'h6000_0000 + c, RESP_OKAY);
    checkVal("steerIdle", arbIdle, 1);

    // Out-of-range CID
    applyStimulus(4'h0, 4'hF, 1'b1, 2, 32'hBAD0_0007, RESP_DECERR);
    checkVal("badSet", errBadcid, 1);
    checkVal("badNoLoad", clRvalid, 0);
    checkVal("badIdle", arbIdle, 1);
    applyStimulus(4'h0, 4'hF, 1'b1, 0, '0, RESP_OKAY);
    checkVal("badHold", errBadcid, 1);

    // Random traffic with a reset in the middle of it
    doReset();
    for (int c = 0; c < 400; c++) begin
      int r;
      if (c == 200) doReset();
      clAraddr = {$urandom, $urandom, $urandom, $urandom};
      r = $urandom_range(0, 99);
      applyStimulus(4'($urandom), 4'($urandom) | 4'($urandom), ($urandom_range(0, 3) != 0),
                    (r < 60) ? 1 : ((r < 62) ? 2 : 0), $urandom, 2'($urandom));
    end
    for (int c = 0; c < 40; c++) applyStimulus(4'h0, 4'hF, 1'b1, 1, $urandom, RESP_OKAY);
    checkVal("rndIdle", arbIdle, 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/vxe_biu_rd_arb.md
Name: vxe_biu_rd_arb

Overview:
- Read-request arbiter and response router that sits directly upstream of the AXI4 master BIU read path.
- Merges NCLIENTS read clients onto the single BIU read interface (biu_ar*/biu_r*). Client index is carried as CID.
- Steers each BIU read response back to the client selected by its CID.
- Bounds per-client outstanding reads.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- CID_WIDTH, 8, client-id width; must match BIU CID_WIDTH.
- NCLIENTS, 4, number of clients, 2..2^CID_WIDTH.
- MAX_OUTST, 4, maximum outstanding reads per client, 1..15.

Ports:
- M_AXI4_ACLK  in  1  clock.
- M_AXI4_ARESETn  in  1  asynchronous, active-low reset.
- cl_arvalid  in  NCLIENTS  per-client request valid.
- cl_araddr  in  NCLIENTS*ADDR_WIDTH  per-client address; client i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- cl_arpop  out  NCLIENTS  per-client request accepted; one-hot or zero.
- cl_rvalid  out  NCLIENTS  per-client response valid; one-hot or zero.
- cl_rdata  out  DATA_WIDTH  response data, shared by all clients.
- cl_rresp  out  2  response code, shared by all clients.
- cl_rready  in  NCLIENTS  per-client response ready.
- biu_arcid  out  CID_WIDTH  request to BIU: client index, zero-extended.
- biu_araddr  out  ADDR_WIDTH  request address to BIU.
- biu_arvalid  out  1  request valid to BIU.
- biu_arpop  in  1  BIU accepts request.
- biu_rcid  in  CID_WIDTH  response client id from BIU.
- biu_rdata  in  DATA_WIDTH  response data from BIU.
- biu_rresp  in  2  response code from BIU.
- biu_rpush  in  1  response valid from BIU.
- biu_rready  out  1  arbiter can take a response.
- arb_idle  out  1  no request held and all counters zero.
- err_badcid  out  1  sticky: response arrived with an out-of-range CID.

Behaviour:
- Reset values:
  - biu_arvalid=0, biu_arcid=0, biu_araddr=0.
  - Response register empty, so all cl_rvalid=0; cl_rdata=0, cl_rresp=0.
  - err_badcid=0, arb_idle=1.
  - Outstanding counters=0; round-robin pointer=0.
- Handshake rules:
  - Request transfer from client i on the clock edge where cl_arvalid[i] && cl_arpop[i].
  - Request transfer to the BIU on the edge where biu_arvalid && biu_arpop.
  - Response transfer from the BIU on the edge where biu_rpush && biu_rready.
  - Response transfer to client i on the edge where cl_rvalid[i] && cl_rready[i].
- Request slot: one output register holding cid and addr.
  - slot_free = ~biu_arvalid || biu_arpop.
- Client eligibility: client i is eligible when cl_arvalid[i] && cnt[i] != MAX_OUTST.
- Grant (combinational):
  - When slot_free and at least one client is eligible, cl_arpop is asserted one-hot for the first eligible client, searching from rr_ptr upward and wrapping modulo NCLIENTS.
  - cl_arpop is never asserted when slot_free=0.
- On a grant of client g:
  - The slot loads {g, addr_g} and biu_arvalid=1 on the next cycle.
  - rr_ptr becomes (g+1) mod NCLIENTS.
  - cnt[g] increments.
- When the slot is free with no grant, biu_arvalid goes 0 next cycle.
- Latency and throughput:
  - Request latency is 1 cycle from pop to biu_arvalid.
  - Back-to-back grants every cycle while biu_arpop is held high.
- Response register: one entry holding cid, data and resp, plus a valid flag.
  - biu_rready = ~rv || cl_rready[rcid_q], combinational.
  - cl_rvalid[i] = rv && (rcid_q == i).
  - cl_rdata and cl_rresp are driven from the register.
- On response capture, rv=1 on the next cycle, with data loaded.
- On delivery to the client without a simultaneous capture, rv goes 0 and cnt[rcid_q] decrements.
- Out-of-range CID (biu_rcid >= NCLIENTS):
  - The response is accepted (biu_rready behaves as above) but never loaded.
  - err_badcid sets and holds until reset.
  - No counter changes.
- Simultaneous events:
  - Increment and decrement of the same counter in one cycle leave it unchanged.
  - Capture and delivery in the same cycle reload the register, so rv stays 1.
- Counter width is 4 bits.
  - An increment at MAX_OUTST cannot occur, because the client is ineligible.
  - A decrement at 0 cannot occur for a legal CID.
- arb_idle = ~biu_arvalid && ~rv && all cnt==0.
- Reset mid-operation clears everything asynchronously; in-flight BIU transactions are the system's responsibility.

Decomposition:
- Shared package vxe_biu_pkg holds:
  - AXI response codes OKAY/EXOKAY/SLVERR/DECERR;
  - a clog2 function;
  - the client-index width rule.
- One sub-module: vxe_rr_arb, an NCLIENTS-wide round-robin priority selector taking a request vector and rr_ptr and producing a one-hot grant plus an index. It is purely combinational.
- The pointer register stays in the parent.

Test Plan:
- Single client: client 0 issues addr 0x1000 and biu_arpop is held at 1.
  - biu_arvalid=1 with cid=0 and addr 0x1000 one cycle after cl_arpop[0].
  - BIU then pushes cid 0, data 0xDEADBEEF, resp OKAY; cl_rvalid[0]=1 with that data; cnt returns to 0 and arb_idle=1.
- Fairness: all 4 clients are continuously valid and biu_arpop=1.
  - Grant order is 0,1,2,3,0,1; each client gets exactly 25% of grants over 40 cycles.
- Backpressure: biu_arpop=0 for 5 cycles with clients valid.
  - biu_arvalid, biu_arcid and biu_araddr stay stable; cl_arpop=0 throughout; no request is lost when pop returns.
- Outstanding limit: client 2 is valid with no responses returned.
  - After 4 grants cl_arpop[2] stays 0.
  - One response with cid 2 delivered gives exactly one further grant.
- Response steering: responses are pushed with cid 3, 1, 3 while cl_rready[1]=0.
  - biu_rready=0 while the cid-1 response is held.
  - Data order per client is preserved and cl_rvalid is never multi-hot.
- Bad CID and reset:
  - A push with cid 7 (NCLIENTS=4) sets err_badcid; counters are unchanged.
  - Asserting M_AXI4_ARESETn=0 mid-burst clears all outputs to their reset values immediately.
